// File: rtl/fpga_pll_reconfig.sv
`timescale 1ns/1ps
// Reconfiguration sequencer for the HDMI rPLL. It loads the divider codes for a
// mode, pulses the PLL reset, waits for a stable lock and retries on a timeout.
module fpga_pll_reconfig #(
  parameter int INIT_MODE   = 0,
  parameter int SETUP_CYC   = 4,
  parameter int RST_CYC     = 27,
  parameter int LOCK_TO_CYC = 270000,
  parameter int SETTLE_CYC  = 2700,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk_ext,
  input  logic       arst_n,
  input  logic       req_valid,
  input  logic       req_mode,
  output logic       req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       cur_mode,
  output logic       video_en,
  output logic       done,
  output logic       fail
);

  localparam int MAX_A   = (SETUP_CYC > RST_CYC) ? SETUP_CYC : RST_CYC;
  localparam int MAX_B   = (LOCK_TO_CYC > SETTLE_CYC) ? LOCK_TO_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int RTR_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic INIT_M = 1'(INIT_MODE);

  typedef enum logic [2:0] {IDLE, APPLY, RST, WAIT_LOCK, SETTLE} state_t;

  // rPLL divider ports take the bit-inverted divide value
  function automatic logic [17:0] div_codes(input logic m);
    return m ? 18'b111101_110010_111110 : 18'b111110_101000_111111;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [RTR_W-1:0] retry, retry_n;
  logic             lock_meta, lock_s, good;
  logic             accept, succeed, give_up, timeout;

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    retry_n = retry;
    accept  = 1'b0;
    succeed = 1'b0;
    give_up = 1'b0;
    timeout = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        retry_n = '0;
        state_n = APPLY;
        cnt_n   = CNT_W'(SETUP_CYC);
      end
      APPLY: if (cnt == '0) begin
        state_n = RST;
        cnt_n   = CNT_W'(RST_CYC - 1);
      end
      RST: if (cnt == '0) begin
        state_n = WAIT_LOCK;
        cnt_n   = CNT_W'(LOCK_TO_CYC);
      end
      WAIT_LOCK: if (lock_s) begin
        state_n = SETTLE;
        cnt_n   = CNT_W'(SETTLE_CYC);
      end else if (cnt == '0) begin
        timeout = 1'b1;
      end
      SETTLE: if (!lock_s) begin
        timeout = 1'b1;
      end else if (cnt == '0) begin
        succeed = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    // a lock drop during settling is treated exactly like a lock timeout
    if (timeout) begin
      if (retry < RTR_W'(MAX_RETRY)) begin
        retry_n = retry + RTR_W'(1);
        state_n = APPLY;
        cnt_n   = CNT_W'(SETUP_CYC);
      end else begin
        give_up = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk_ext or negedge arst_n) begin
    if (!arst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= CNT_W'(LOCK_TO_CYC);
      retry     <= '0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_ext or negedge arst_n) begin
    if (!arst_n) begin
      cur_mode              <= INIT_M;
      {idsel, fbdsel, odsel} <= div_codes(INIT_M);
      pll_reset             <= 1'b0;
      req_ready             <= 1'b0;
      video_en              <= 1'b0;
      done                  <= 1'b0;
      fail                  <= 1'b0;
      good                  <= 1'b0;
    end else begin
      pll_reset <= (state_n == RST);
      req_ready <= (state_n == IDLE);
      done      <= succeed;
      // held low on the accept cycle so the new sequence never sees it high
      video_en  <= good & lock_s & (state == IDLE) & (state_n == IDLE);
      if (accept) begin
        cur_mode               <= req_mode;
        {idsel, fbdsel, odsel} <= div_codes(req_mode);
        fail                   <= 1'b0;
        good                   <= 1'b0;
      end
      if (give_up) begin
        fail <= 1'b1;
        good <= 1'b0;
      end
      if (succeed) good <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_pll_reconfig.sv
`timescale 1ns/1ps
// Scoreboard bench: a PLL model answers each reset pulse from a plan queue, and
// the expected outcome of every sequence is queued when the request is issued.
module tb_fpga_pll_reconfig;
  localparam int SETUP = 2, RSTC = 3, LOCKTO = 20, SETTLE = 5, MAXR = 1;

  logic clk_ext = 1'b0, arst_n = 1'b0, req_valid = 1'b0, req_mode = 1'b0, pll_lock = 1'b0;
  logic req_ready, pll_reset, cur_mode, video_en, done, fail;
  logic [5:0] idsel, fbdsel, odsel;

  typedef struct {int ty; int d;} plan_t;            // ty 0 lock, 1 never, 2 lock then drop
  typedef struct {bit ok; bit mode; int pulses;} exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    total = 0, bad = 0, cyc = 0;
  bit    force_low = 1'b0;
  bit    last_mode = 1'b0;

  fpga_pll_reconfig #(.INIT_MODE(0), .SETUP_CYC(SETUP), .RST_CYC(RSTC),
    .LOCK_TO_CYC(LOCKTO), .SETTLE_CYC(SETTLE), .MAX_RETRY(MAXR)) dut (
    .clk_ext(clk_ext), .arst_n(arst_n), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel),
    .fbdsel(fbdsel), .odsel(odsel), .cur_mode(cur_mode), .video_en(video_en),
    .done(done), .fail(fail));

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int codes(input bit m);
    logic [17:0] c;
    c = m ? 18'b111101_110010_111110 : 18'b111110_101000_111111;
    return int'(c);
  endfunction

  task automatic step();
    @(posedge clk_ext);
    #2;
  endtask

  initial forever begin
    @(posedge clk_ext);
    cyc = cyc + 1;
  end

  // PLL model: loses lock under reset, then follows the next plan entry
  initial begin
    plan_t cur;
    bit armed, active;
    int t;
    cur = '{1, 0};
    armed = 1'b1; active = 1'b0; t = 0;
    forever begin
      @(negedge clk_ext);
      if (!arst_n || pll_reset) begin
        pll_lock = 1'b0; armed = 1'b1; active = 1'b0;
      end else begin
        if (armed) begin
          armed = 1'b0;
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front(); active = 1'b1; t = 0;
          end
        end else if (active) t++;
        pll_lock = active && !force_low &&
                   ((cur.ty == 0 && t >= cur.d) || (cur.ty == 2 && t >= cur.d && t < cur.d + 3));
      end
    end
  end

  // monitor: pops one expectation per done pulse or fail rise
  initial begin
    int pulses, hi, acc_edge;
    bit prst_q, fail_q, done_q, acc_pend, div_chk, ven_chk, div_mode;
    exp_t e;
    pulses = 0; hi = 0; acc_edge = 0;
    prst_q = 0; fail_q = 0; done_q = 0; acc_pend = 0; div_chk = 0; ven_chk = 0; div_mode = 0;
    forever begin
      @(negedge clk_ext);
      if (!arst_n) begin
        pulses = 0; hi = 0; prst_q = 0; fail_q = 0; done_q = 0;
        acc_pend = 0; div_chk = 0; ven_chk = 0;
      end else begin
        if (div_chk) begin
          chk("div_after_accept", int'({idsel, fbdsel, odsel}), codes(div_mode));
          chk("cur_mode_after_accept", int'(cur_mode), int'(div_mode));
          chk("fail_cleared_on_accept", int'(fail), 0);
          div_chk = 0;
        end
        if (ven_chk) begin
          chk("video_en_after_done", int'(video_en), 1);
          ven_chk = 0;
        end
        if (pll_reset && !prst_q) begin
          pulses++; hi = 1;
          if (acc_pend) begin
            chk("accept_to_pll_reset", cyc - acc_edge, SETUP + 1);
            acc_pend = 0;
          end
        end else if (pll_reset) hi++;
        if (!pll_reset && prst_q) chk("pll_reset_width", hi, RSTC);
        if (done) begin
          chk("done_one_cycle", int'(done_q), 0);
          chk("video_en_with_done", int'(video_en), 0);
          if (exp_q.size() == 0) chk("unexpected_done", 1, int'(fail));
          else begin
            e = exp_q.pop_front();
            chk("outcome_ok", 1, int'(e.ok));
            chk("done_mode", int'(cur_mode), int'(e.mode));
            chk("done_dividers", int'({idsel, fbdsel, odsel}), codes(e.mode));
            chk("done_attempts", pulses, e.pulses);
          end
          ven_chk = !(req_valid && req_ready);
        end
        if (fail && !fail_q) begin
          if (exp_q.size() == 0) chk("unexpected_fail", 0, int'(fail));
          else begin
            e = exp_q.pop_front();
            chk("outcome_fail", 0, int'(e.ok));
            chk("fail_attempts", pulses, e.pulses);
            chk("fail_req_ready", int'(req_ready), 1);
            chk("fail_video_en", int'(video_en), 0);
          end
        end
        if (req_valid && req_ready) begin
          acc_pend = 1; acc_edge = cyc + 1; pulses = 0;
          div_chk = 1; div_mode = req_mode;
        end
        prst_q = pll_reset; fail_q = fail; done_q = done;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 400 && !req_ready; k++) step();
    chk("return_to_idle", int'(req_ready), 1);
  endtask

  task automatic powerup_expect();
    plan_q.push_back('{0, 10});
    exp_q.push_back('{1'b1, 1'b0, 0});
    last_mode = 1'b0;
  endtask

  // queue the plans and the outcome the rules imply, then present the request
  task automatic issue(input bit m, input int ty0, input int ty1, input bit no_wait);
    int n, k, ty;
    bit ok, hold_bad;
    n = 0; ok = 0;
    for (int a = 0; a <= MAXR; a++) begin
      ty = (a == 0) ? ty0 : ty1;
      plan_q.push_back('{ty, (ty == 2) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 12))});
      n++;
      if (ty == 0) begin ok = 1; break; end
    end
    exp_q.push_back('{ok, m, n});
    req_mode = m; req_valid = 1'b1; hold_bad = 0;
    for (k = 0; k < 400 && !req_ready; k++) begin
      if (cur_mode != last_mode) hold_bad = 1;
      step();
    end
    if (k > 0) chk("held_req_ignored", int'(hold_bad), 0);
    chk("req_accepted", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    last_mode = m;
    if (!no_wait) wait_idle();
  endtask

  initial begin
    int k;
    bit ok;
    repeat (60000) @(posedge clk_ext);
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int r0, r1;
    powerup_expect();
    repeat (3) step();
    chk("rst_pll_reset", int'(pll_reset), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_video_en", int'(video_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_cur_mode", int'(cur_mode), 0);
    chk("rst_dividers", int'({idsel, fbdsel, odsel}), codes(1'b0));
    arst_n = 1'b1;
    wait_idle();
    repeat (2) step();
    chk("powerup_video_en", int'(video_en), 1);

    issue(1'b1, 0, 0, 1'b0);
    issue(1'b0, 1, 1, 1'b0);
    repeat (3) step();
    chk("fail_sticky", int'(fail), 1);
    chk("fail_idle_ready", int'(req_ready), 1);
    issue(1'b0, 2, 0, 1'b0);
    issue(1'b1, 0, 0, 1'b1);
    issue(1'b0, 0, 0, 1'b0);

    // lock loss while idle: video_en drops, no automatic resequencing
    repeat (2) step();
    chk("idle_video_en", int'(video_en), 1);
    force_low = 1'b1;
    for (int k = 0; k < 8 && video_en; k++) step();
    chk("lock_loss_video_en", int'(video_en), 0);
    ok = 1;
    repeat (10) begin
      step();
      if (!req_ready || pll_reset) ok = 0;
    end
    chk("no_auto_recover", int'(ok), 1);
    force_low = 1'b0;
    repeat (5) step();

    for (int i = 0; i < 30; i++) begin
      r0 = int'($urandom_range(0, 4)); r1 = int'($urandom_range(0, 4));
      r0 = (r0 <= 2) ? 0 : r0 - 2;
      r1 = (r1 <= 2) ? 0 : r1 - 2;
      issue(1'($urandom_range(0, 1)), r0, r1, (i < 29) && ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset while the PLL reset pulse is high
    issue(1'b1, 1, 1, 1'b1);
    for (int k = 0; k < 20 && !pll_reset; k++) step();
    chk("saw_pll_reset", int'(pll_reset), 1);
    #1 arst_n = 1'b0;
    #1;
    chk("arst_pll_reset_drop", int'(pll_reset), 0);
    chk("arst_cur_mode", int'(cur_mode), 0);
    chk("arst_dividers", int'({idsel, fbdsel, odsel}), codes(1'b0));
    chk("arst_req_ready", int'(req_ready), 0);
    exp_q.delete();
    plan_q.delete();
    powerup_expect();
    repeat (3) step();
    arst_n = 1'b1;
    wait_idle();

    repeat (10) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
